// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT coefficient collector.
// DCT_COLLECT_QUANT_EN adds the per-index quantizer shift table.
package dct_pkg;

   localparam int DCT_N      = 16;
   localparam int DCT_IDX_W  = 4;
   localparam int DCT_COEF_W = 18;

   typedef logic signed [DCT_COEF_W-1:0] coef_t;

   typedef enum logic {
      RD_IDLE,
      RD_STREAM
   } rd_state_e;

`ifdef DCT_COLLECT_QUANT_EN
   localparam logic [3:0] QSHIFT [DCT_N] = '{
      4'd0, 4'd1, 4'd1, 4'd2,
      4'd2, 4'd2, 4'd3, 4'd3,
      4'd3, 4'd3, 4'd4, 4'd4,
      4'd4, 4'd4, 4'd4, 4'd4
   };
`endif

endpackage

// File: rtl/dct_coeff_bank.sv
// One block bank: dual write port, one read port, fill mask, full flag.
// Ports: wr_en/idx_a/idx_b/din_a/din_b write a pair, free releases a
// full bank, rd_idx/rd_data read (bypassing same-edge writes),
// full/complete/dup/partial report bank status.
module dct_coeff_bank #(
   parameter int DATA_W = 18,
   parameter int N      = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  idx_a,
   input  logic [IDX_W-1:0]  idx_b,
   input  logic [DATA_W-1:0] din_a,
   input  logic [DATA_W-1:0] din_b,
   input  logic              free,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              complete,
   output logic              dup,
   output logic              partial
);

   logic [DATA_W-1:0] mem_q [N];
   logic [DATA_W-1:0] mem_d [N];
   logic [N-1:0]      mask_q, mask_d, set_m;
   logic              full_q, full_d;

   always_comb begin
      mem_d    = mem_q;
      set_m    = mask_q;
      dup      = 1'b0;
      complete = 1'b0;
      if (wr_en) begin
         // b is written last so it wins when both indices match
         mem_d[idx_a] = din_a;
         mem_d[idx_b] = din_b;
         set_m = mask_q | (N'(1) << idx_a) | (N'(1) << idx_b);
         dup   = (idx_a == idx_b) | mask_q[idx_a] | mask_q[idx_b];
         complete = &set_m;
      end
      mask_d = complete ? '0 : set_m;
      full_d = (full_q & ~free) | complete;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
         full_q <= 1'b0;
      end else begin
         mask_q <= mask_d;
         full_q <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // next-state read lets idx 0 leave on the completing edge
   assign rd_data = mem_d[rd_idx];
   assign full    = full_q;
   assign partial = |mask_q;

endmodule

// File: rtl/dct_coeff_collector.sv
// Collects DCT coefficient pairs into ping-pong banks and streams each
// block out in index order 0..N-1 over valid/ready.
// Ports: in_en/in_a/in_b/idx_a/idx_b input pairs; out_data/out_idx/
// out_valid/out_ready/out_last output stream; overflow/dup_err sticky
// flags; busy. DCT_COLLECT_QUANT_EN enables the output quantizer.
module dct_coeff_collector
   import dct_pkg::*;
#(
   parameter int DATA_W = DCT_COEF_W,
   parameter int N      = DCT_N,
   parameter int IDX_W  = DCT_IDX_W,
   parameter int OUT_W  = 18
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_en,
   input  logic [DATA_W-1:0]       in_a,
   input  logic [DATA_W-1:0]       in_b,
   input  logic [IDX_W-1:0]        idx_a,
   input  logic [IDX_W-1:0]        idx_b,
   output logic signed [OUT_W-1:0] out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    overflow,
   output logic                    dup_err,
   output logic                    busy
);

   localparam int W2 = DATA_W + 2;
   localparam int OMAX_I = (1 << (OUT_W - 1)) - 1;
   localparam logic signed [W2-1:0] OMAX = W2'(OMAX_I);
   localparam logic signed [W2-1:0] OMIN = -OMAX - W2'(1);

   function automatic logic signed [OUT_W-1:0] sat(
      input logic signed [W2-1:0] v
   );
      if (v > OMAX)      sat = OMAX[OUT_W-1:0];
      else if (v < OMIN) sat = OMIN[OUT_W-1:0];
      else               sat = v[OUT_W-1:0];
   endfunction

`ifdef DCT_COLLECT_QUANT_EN
   // arithmetic shift with round half away from zero
   function automatic logic signed [W2-1:0] quant(
      input logic signed [W2-1:0] w,
      input logic [IDX_W-1:0]     idx
   );
      logic [3:0]          s;
      logic signed [W2-1:0] mag, half, r;
      s    = QSHIFT[idx];
      mag  = w[W2-1] ? -w : w;
      half = (s == 4'd0) ? '0 : (W2'(1) << (s - 4'd1));
      r    = (mag + half) >>> s;
      quant = w[W2-1] ? -r : r;
   endfunction
`endif

   logic                    wr_bank_q, wr_bank_d;
   logic                    rd_bank_q, rd_bank_d;
   rd_state_e               state_q, state_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]        out_idx_q, out_idx_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    overflow_q, overflow_d;
   logic                    dup_q, dup_d;

   logic [1:0]        wr_en, full, complete, dup, partial, free, avail;
   logic [DATA_W-1:0] rd_data [2];
   logic              ld, ld_bank;
   logic [IDX_W-1:0]  ld_idx;
   logic signed [W2-1:0] ld_ext;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign wr_en[b] = in_en & (wr_bank_q == 1'(b)) & ~full[b];

      dct_coeff_bank #(
         .DATA_W (DATA_W),
         .N      (N),
         .IDX_W  (IDX_W)
      ) u_bank (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_en[b]),
         .idx_a    (idx_a),
         .idx_b    (idx_b),
         .din_a    (in_a),
         .din_b    (in_b),
         .free     (free[b]),
         .rd_idx   (ld_idx),
         .rd_data  (rd_data[b]),
         .full     (full[b]),
         .complete (complete[b]),
         .dup      (dup[b]),
         .partial  (partial[b])
      );
   end

   assign avail = full | complete;

   always_comb begin
      wr_bank_d  = wr_bank_q ^ (|complete);
      overflow_d = overflow_q | (in_en & full[wr_bank_q]);
      dup_d      = dup_q | (|dup);
   end

   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      free        = '0;
      ld          = 1'b0;
      ld_bank     = rd_bank_q;
      ld_idx      = out_idx_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      unique case (state_q)
         RD_IDLE: begin
            if (avail[rd_bank_q]) begin
               state_d = RD_STREAM;
               ld      = 1'b1;
               ld_idx  = '0;
            end
         end
         RD_STREAM: begin
            if (out_ready) begin
               if (out_last_q) begin
                  free[rd_bank_q] = 1'b1;
                  rd_bank_d = ~rd_bank_q;
                  ld_bank   = ~rd_bank_q;
                  if (avail[~rd_bank_q]) begin
                     ld     = 1'b1;
                     ld_idx = '0;
                  end else begin
                     state_d     = RD_IDLE;
                     out_valid_d = 1'b0;
                     out_last_d  = 1'b0;
                  end
               end else begin
                  ld     = 1'b1;
                  ld_idx = out_idx_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      ld_ext = $signed({{2{rd_data[ld_bank][DATA_W-1]}},
                        rd_data[ld_bank]});
      if (ld) begin
`ifdef DCT_COLLECT_QUANT_EN
         out_data_d = sat(quant(ld_ext, ld_idx));
`else
         out_data_d = sat(ld_ext);
`endif
         out_idx_d   = ld_idx;
         out_valid_d = 1'b1;
         out_last_d  = (ld_idx == IDX_W'(N - 1));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         state_q     <= RD_IDLE;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
         dup_q       <= 1'b0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
         dup_q       <= dup_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign overflow  = overflow_q;
   assign dup_err   = dup_q;
   assign busy      = (|partial) | (|full);

endmodule

// File: tb/tb_dct_coeff_collector.sv
// Self-checking bench for dct_coeff_collector against a block-queue model.
// Honours DCT_COLLECT_QUANT_EN in its expected-value model.
module tb_dct_coeff_collector;
   import dct_pkg::*;

   localparam int DW = 18;
   localparam int N  = 16;
   localparam int IW = 4;
   localparam int OW = 12;

   logic                 clk = 1'b0;
   logic                 reset, in_en, out_ready;
   logic [DW-1:0]        in_a, in_b;
   logic [IW-1:0]        idx_a, idx_b;
   logic signed [OW-1:0] out_data;
   logic [IW-1:0]        out_idx;
   logic                 out_valid, out_last, overflow, dup_err, busy;

   always #5 clk = ~clk;

   dct_coeff_collector #(
      .DATA_W (DW), .N (N), .IDX_W (IW), .OUT_W (OW)
   ) dut (
      .clk (clk), .reset (reset), .in_en (in_en),
      .in_a (in_a), .in_b (in_b), .idx_a (idx_a), .idx_b (idx_b),
      .out_data (out_data), .out_idx (out_idx),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_last (out_last), .overflow (overflow),
      .dup_err (dup_err), .busy (busy)
   );

   typedef int blk_t [N];
   typedef struct { int idx; int data; bit last; } beat_t;

   int    errors = 0;
   int    checks = 0;
   blk_t  mq[$];
   int    part [N];
   bit    pmask [N];
   int    mk;
   bit    m_ovf, m_dup;
   int    ready_mode;
   beat_t log_q[$];
   int    run, max_run;
   int    pa [16], pb [16], va [16], vb [16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic int m_conv(input int v, input int idx);
      int r, m, hi;
      r = v;
`ifdef DCT_COLLECT_QUANT_EN
      begin
         int s;
         s = int'(QSHIFT[idx]);
         if (s > 0) begin
            m = (r < 0) ? -r : r;
            m = (m + (1 << (s - 1))) >> s;
            r = (r < 0) ? -m : m;
         end
      end
`else
      m = idx;
`endif
      hi = (1 << (OW - 1)) - 1;
      if (r > hi) r = hi;
      if (r < -hi - 1) r = -hi - 1;
      return r;
   endfunction

   function automatic int rnd_val();
      logic signed [DW-1:0] r;
      r = DW'($urandom);
      if ($urandom_range(0, 1) == 0) return int'(r);
      return int'($urandom_range(0, 4000)) - 2000;
   endfunction

   task automatic model_clear();
      mq.delete();
      mk = 0;
      m_ovf = 0;
      m_dup = 0;
      for (int i = 0; i < N; i++) pmask[i] = 0;
   endtask

   task automatic model_step(input bit en, input int ai, input int bi,
                             input int av, input int bv, input bit rdy);
      int pre;
      bit all;
      blk_t nb;
      pre = mq.size();
      if (en) begin
         if (pre == 2) m_ovf = 1;
         else begin
            if (pmask[ai]) m_dup = 1;
            part[ai] = av;
            pmask[ai] = 1;
            if (pmask[bi]) m_dup = 1;
            part[bi] = bv;
            pmask[bi] = 1;
            all = 1;
            for (int i = 0; i < N; i++) if (!pmask[i]) all = 0;
            if (all) begin
               nb = part;
               mq.push_back(nb);
               for (int i = 0; i < N; i++) pmask[i] = 0;
            end
         end
      end
      if (pre > 0 && rdy) begin
         mk++;
         if (mk == N) begin
            mq.delete(0);
            mk = 0;
         end
      end
   endtask

   task automatic check_outputs();
      bit ev, pb_any;
      ev = (mq.size() > 0);
      pb_any = 0;
      for (int i = 0; i < N; i++) if (pmask[i]) pb_any = 1;
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev) begin
         chk("out_idx", int'(out_idx), mk);
         chk("out_data", int'(out_data), m_conv(mq[0][mk], mk));
         chk("out_last", int'(out_last), int'(mk == N - 1));
      end
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("dup_err", int'(dup_err), int'(m_dup));
      chk("busy", int'(busy), int'(pb_any || ev));
      if (out_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
   endtask

   task automatic cycle();
      bit sv, sr;
      beat_t b;
      sv = out_valid;
      sr = out_ready;
      b.idx = int'(out_idx);
      b.data = int'(out_data);
      b.last = out_last;
      @(posedge clk);
      if (sv && sr) log_q.push_back(b);
      model_step(in_en, int'(idx_a), int'(idx_b),
                 int'($signed(in_a)), int'($signed(in_b)), out_ready);
      #1 check_outputs();
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic idle(input int n);
      in_en = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic drive(input int i);
      in_en = 1'b1;
      idx_a = IW'(pa[i]);
      idx_b = IW'(pb[i]);
      in_a  = DW'(va[i]);
      in_b  = DW'(vb[i]);
   endtask

   task automatic send(input int np, input int gap);
      for (int i = 0; i < np; i++) begin
         drive(i);
         cycle();
         if (gap > 0 && $urandom_range(0, 99) < gap) begin
            in_en = 1'b0;
            cycle();
         end
      end
      in_en = 1'b0;
   endtask

   task automatic perm_block();
      int perm [N];
      int j, t;
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
         pa[i] = perm[2*i];
         pb[i] = perm[2*i+1];
         va[i] = rnd_val();
         vb[i] = rnd_val();
      end
   endtask

   task automatic lit_beat(input string name, input int k, input int exp);
      if (log_q.size() > k) chk(name, log_q[k].data, exp);
      else chk({name, "_missing"}, log_q.size(), k + 1);
   endtask

   initial begin
      int e;
      bit hit;
      reset = 1'b1;
      in_en = 1'b0;
      in_a = '0;
      in_b = '0;
      idx_a = '0;
      idx_b = '0;
      out_ready = 1'b1;
      ready_mode = 0;
      run = 0;
      max_run = 0;
      model_clear();
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_idx", int'(out_idx), 0);
      chk("rst_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_dup", int'(dup_err), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // one ordered block, value = 100*idx
      for (int i = 0; i < 8; i++) begin
         pa[i] = i;
         pb[i] = i + 8;
         va[i] = 100 * i;
         vb[i] = 100 * (i + 8);
      end
      log_q.delete();
      send(8, 0);
      chk("t1_valid_after_last", int'(out_valid), 1);
      chk("t1_idx0", int'(out_idx), 0);
      idle(20);
      chk("t1_beats", log_q.size(), 16);
      for (int i = 0; i < 16 && i < log_q.size(); i++) begin
         e = 100 * i;
`ifdef DCT_COLLECT_QUANT_EN
         e = m_conv(e, i);
`endif
         chk("t1_data", log_q[i].data, e);
         chk("t1_idx", log_q[i].idx, i);
         chk("t1_last", int'(log_q[i].last), int'(i == 15));
      end

      // two back-to-back blocks
      log_q.delete();
      max_run = 0;
      perm_block();
      send(8, 0);
      perm_block();
      send(8, 0);
      idle(40);
      chk("t2_beats", log_q.size(), 32);
      chk("t2_no_bubble", max_run, 32);

      // consumer stalled over three blocks
      ready_mode = 1;
      out_ready = 1'b0;
      log_q.delete();
      repeat (3) begin
         perm_block();
         send(8, 0);
      end
      chk("t3_overflow", int'(overflow), 1);
      ready_mode = 0;
      out_ready = 1'b1;
      idle(40);
      chk("t3_beats", log_q.size(), 32);

      // duplicate index inside one pair
      chk("t4_dup_before", int'(dup_err), 0);
      log_q.delete();
      pa[0] = 5;  pb[0] = 5;  va[0] = -7;  vb[0] = 9;
      pa[1] = 0;  pb[1] = 1;  pa[2] = 2;  pb[2] = 3;
      pa[3] = 4;  pb[3] = 6;  pa[4] = 7;  pb[4] = 8;
      pa[5] = 9;  pb[5] = 10; pa[6] = 11; pb[6] = 12;
      pa[7] = 13; pb[7] = 14;
      for (int i = 1; i < 8; i++) begin
         va[i] = 10 * i;
         vb[i] = -10 * i;
      end
      send(8, 0);
      chk("t4_dup_flag", int'(dup_err), 1);
      chk("t4_busy_partial", int'(busy), 1);
      pa[0] = 15; pb[0] = 15; va[0] = 3; vb[0] = 4;
      send(1, 0);
      idle(20);
      chk("t4_beats", log_q.size(), 16);
      e = 9;
`ifdef DCT_COLLECT_QUANT_EN
      e = m_conv(e, 5);
`endif
      lit_beat("t4_idx5", 5, e);

      // async reset while streaming, with a partial block pending
      log_q.delete();
      perm_block();
      send(8, 0);
      perm_block();
      hit = 0;
      for (int t = 0; t < 20 && !hit; t++) begin
         if (t < 3) drive(t);
         else in_en = 1'b0;
         cycle();
         hit = out_valid && (out_idx == 4'd6);
      end
      in_en = 1'b0;
      chk("t5_reach_beat6", int'(hit), 1);
      #2 reset = 1'b1;
      #1;
      chk("t5_valid_drop", int'(out_valid), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_ovf_clr", int'(overflow), 0);
      chk("t5_dup_clr", int'(dup_err), 0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      log_q.delete();
      perm_block();
      send(8, 0);
      idle(20);
      chk("t5_beats", log_q.size(), 16);
      if (log_q.size() > 0) chk("t5_first_idx", log_q[0].idx, 0);

      // saturation and rounding corners
      log_q.delete();
      for (int i = 0; i < 8; i++) begin
         pa[i] = i;
         pb[i] = i + 8;
         va[i] = 100 * i;
         vb[i] = -100 * i;
      end
      va[0] = 131071;
      va[1] = -131072;
      va[3] = -6;
      send(8, 0);
      idle(20);
      lit_beat("t6_sat_hi", 0, 2047);
      lit_beat("t6_sat_lo", 1, -2048);
`ifdef DCT_COLLECT_QUANT_EN
      lit_beat("t6_round", 3, -2);
`else
      lit_beat("t6_pass", 3, -6);
`endif

      // randomized traffic and backpressure
      ready_mode = 2;
      repeat (25) begin
         perm_block();
         if ($urandom_range(0, 7) == 0) pb[3] = pa[3];
         send(8, 30);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 12)));
      end
      ready_mode = 0;
      out_ready = 1'b1;
      idle(80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
